uart_word_receiver: RTL and testbench

Serial-to-parallel receiver that is the inbound counterpart of the answer-sending path. It deserializes 8N1 UART frames from the host on `rx` and assembles `NUM_BYTES` consecutive bytes into one wide word, for example a seed population or run parameters. The word is presented on `word_out` with a `done` level when complete. It sits between the board RX pin and the top-level control FSM, which arms it with `start`.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_byte.sv | 102 ++++++++++
 rtl/uart_word_receiver.sv | 92 +++++++++
 tb/tb_uart_word_receiver.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and state types for the receive and transmit paths
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ARMED,
    W_DONE
  } word_state_t;

  typedef enum logic [1:0] {
    RX_WAIT_START,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte deserializer with input synchronizer and mid-bit sampling
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

  rx_state_t        state_q, state_d;
  logic             rx_meta, rx_s, rx_prev;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_d, err_d;

  assign byte_out = shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      state_q    <= RX_WAIT_START;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_valid <= valid_d;
      byte_err   <= err_d;
    end
  end

  // Entering START at count 0 puts the start-bit check CLKS_PER_BIT/2 cycles after detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_WAIT_START: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_prev && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_WAIT_START : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_WAIT_START;
          valid_d = rx_s;
          err_d   = !rx_s;
        end
      end
      default: state_d = RX_WAIT_START;
    endcase
    if (!enable) begin
      state_d = RX_WAIT_START;
      cnt_d   = '0;
      bit_d   = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

endmodule

// File: rtl/uart_word_receiver.sv
// rtl/uart_word_receiver.sv - assembles NUM_BYTES received UART bytes into one word, MSB byte first
module uart_word_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NUM_BYTES    = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rx,
  output logic [8*NUM_BYTES-1:0] word_out,
  output logic                   done,
  output logic                   busy,
  output logic                   frame_error
);

  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  word_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [8*NUM_BYTES-1:0] word_d;
  logic                   fe_d;
  logic [7:0]             rx_byte;
  logic                   rx_valid, rx_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .rst       (rst),
    .enable    (state_q == W_ARMED),
    .rx        (rx),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .byte_err  (rx_err)
  );

  assign done = (state_q == W_DONE);
  assign busy = (state_q == W_ARMED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= W_IDLE;
      cnt_q       <= '0;
      word_out    <= '0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_out    <= word_d;
      frame_error <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_out;
    fe_d    = frame_error;
    case (state_q)
      W_IDLE, W_DONE: begin
        if (start) begin
          state_d = W_ARMED;
          cnt_d   = '0;
          word_d  = '0;
          fe_d    = 1'b0;
        end
      end
      W_ARMED: begin
        if (rx_err) begin
          state_d = W_IDLE;
          fe_d    = 1'b1;
        end else if (rx_valid) begin
          // Byte k of the word lands in slot NUM_BYTES-1-k so the first byte ends up on top.
          for (int i = 0; i < NUM_BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) word_d[8*(NUM_BYTES-1-i) +: 8] = rx_byte;
          end
          if (cnt_q == LAST_BYTE) begin
            state_d = W_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_word_receiver.sv
// tb/tb_uart_word_receiver.sv - self-checking bench for uart_word_receiver with an event-level model
module tb_uart_word_receiver;

  localparam int C        = 4;
  localparam int N        = 3;
  localparam int W        = 8 * N;
  localparam int STOP_LAT = 2 + C / 2 + 9 * C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         rx = 1'b1;
  logic [W-1:0] word_out;
  logic         done, busy, frame_error;

  uart_word_receiver #(
    .CLKS_PER_BIT(C),
    .NUM_BYTES   (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx         (rx),
    .word_out   (word_out),
    .done       (done),
    .busy       (busy),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         when;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  bit           chk_en = 1'b0;
  ev_t          evq[$];
  logic [W-1:0] m_word = '0;
  bit           m_armed = 1'b0;
  bit           m_done = 1'b0;
  bit           m_fe = 1'b0;
  int           m_nb = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Model: a frame takes effect one cycle after its stop sample, if the receiver is armed then.
  always @(posedge clk) begin
    bit was_armed;
    cyc++;
    if (rst) begin
      m_word  = '0;
      m_armed = 1'b0;
      m_done  = 1'b0;
      m_fe    = 1'b0;
      m_nb    = 0;
      evq.delete();
    end else begin
      was_armed = m_armed;
      while (evq.size() > 0 && evq[0].when <= cyc) begin
        if (m_armed && evq[0].when == cyc) begin
          if (evq[0].ok) begin
            m_word = m_word | (W'(evq[0].b) << (8 * (N - 1 - m_nb)));
            m_nb++;
            if (m_nb == N) begin
              m_armed = 1'b0;
              m_done  = 1'b1;
              m_nb    = 0;
            end
          end else begin
            m_armed = 1'b0;
            m_fe    = 1'b1;
          end
        end
        void'(evq.pop_front());
      end
      if (start && !was_armed) begin
        m_armed = 1'b1;
        m_done  = 1'b0;
        m_fe    = 1'b0;
        m_word  = '0;
        m_nb    = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_word", 32'(word_out), rst ? 32'h0 : 32'(m_word));
      check("cyc_done", 32'(done), rst ? 32'h0 : 32'(m_done));
      check("cyc_busy", 32'(busy), rst ? 32'h0 : 32'(m_armed));
      check("cyc_fe", 32'(frame_error), rst ? 32'h0 : 32'(m_fe));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok, input int nbits, output int done_edge);
    logic [9:0] bits;
    ev_t        e;
    bits      = {ok, b, 1'b0};
    done_edge = cyc + 1 + STOP_LAT + 1;
    if (nbits == 10) begin
      e.when = done_edge;
      e.b    = b;
      e.ok   = ok;
      evq.push_back(e);
    end
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (C) step();
    end
    rx = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d;
    #1 chk_en = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    repeat (100) step();
    @(negedge clk);
    check("idle_word", 32'(word_out), 32'h0);
    check("idle_done", 32'(done), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_fe", 32'(frame_error), 32'h0);
    step();

    pulse_start();
    @(negedge clk);
    check("arm_busy", 32'(busy), 32'h1);
    step();
    send_frame(8'hA5, 1'b1, 10, d);
    send_frame(8'h3C, 1'b1, 10, d);
    send_frame(8'h81, 1'b1, 10, d);
    at_edge(d - 1);
    check("nom_done_early", 32'(done), 32'h0);
    check("nom_busy_early", 32'(busy), 32'h1);
    at_edge(d);
    check("nom_done", 32'(done), 32'h1);
    check("nom_busy", 32'(busy), 32'h0);
    check("nom_word", 32'(word_out), 32'hA53C81);
    check("model_nom_word", 32'(m_word), 32'hA53C81);
    step();

    pulse_start();
    @(negedge clk);
    check("rearm_done", 32'(done), 32'h0);
    check("rearm_word", 32'(word_out), 32'h0);
    step();
    rx = 1'b0;
    step();
    rx = 1'b1;
    repeat (12) step();
    @(negedge clk);
    check("glitch_fe", 32'(frame_error), 32'h0);
    check("glitch_busy", 32'(busy), 32'h1);
    check("glitch_word", 32'(word_out), 32'h0);
    step();
    send_frame(8'h55, 1'b1, 10, d);
    at_edge(d);
    check("glitch_next_word", 32'(word_out), 32'h550000);
    step();
    pulse_start();
    @(negedge clk);
    check("ignored_start_word", 32'(word_out), 32'h550000);
    check("ignored_start_busy", 32'(busy), 32'h1);
    step();
    send_frame(8'h01, 1'b1, 10, d);
    send_frame(8'h02, 1'b1, 10, d);
    at_edge(d);
    check("glitch_word_full", 32'(word_out), 32'h550102);
    check("glitch_done", 32'(done), 32'h1);
    step();

    pulse_start();
    send_frame(8'h12, 1'b1, 10, d);
    send_frame(8'h34, 1'b0, 10, d);
    at_edge(d);
    check("ferr_fe", 32'(frame_error), 32'h1);
    check("ferr_done", 32'(done), 32'h0);
    check("ferr_busy", 32'(busy), 32'h0);
    check("ferr_word", 32'(word_out), 32'h120000);
    check("model_ferr_fe", 32'(m_fe), 32'h1);
    step();
    send_frame(8'h99, 1'b1, 10, d);
    at_edge(d + 2);
    check("idle_frame_ignored", 32'(word_out), 32'h120000);
    step();

    pulse_start();
    @(negedge clk);
    check("b2b_fe_clear", 32'(frame_error), 32'h0);
    check("b2b_word_clear", 32'(word_out), 32'h0);
    step();
    send_frame(8'hFF, 1'b1, 10, d);
    send_frame(8'h00, 1'b1, 10, d);
    send_frame(8'h7E, 1'b1, 10, d);
    at_edge(d);
    check("b2b_word", 32'(word_out), 32'hFF007E);
    check("b2b_done", 32'(done), 32'h1);
    step();
    pulse_start();
    @(negedge clk);
    check("rearm2_done", 32'(done), 32'h0);
    check("rearm2_word", 32'(word_out), 32'h0);
    step();

    send_frame(8'h11, 1'b1, 10, d);
    at_edge(d);
    check("rst_pre_word", 32'(word_out), 32'h110000);
    step();
    send_frame(8'h22, 1'b1, 4, d);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check("rst_word", 32'(word_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    send_frame(8'h33, 1'b1, 10, d);
    at_edge(d + 2);
    check("post_rst_word", 32'(word_out), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_fe", 32'(frame_error), 32'h0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
